branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage resolver for the dual-issue pipeline; the producer end of the BPU's resolution/update interface.
- Evaluates the real direction and target of up to two branch/jump instructions per cycle and compares them with the front end's predicted next-PC.
- Drives the registered ex_*/real_*/pred_addr* update bus into the BPU.
- Owns the IF redirect handshake after a mispredict and keeps 32-bit branch and mispredict counters.

Parameters:
- PC_W, 32, width of PCs, operands and targets.
- RESET_PC, 32'h1c000000, value of redirect_pc after reset.

Ports:
- cpu_clk  input  1  clock, all logic on rising edge.
- cpu_rst  input  1  synchronous active-high reset.
- in_valid  input  1  a dual-issue packet is presented.
- in_ready  output  1  unit can accept a packet this cycle.
- flush_in  input  1  squash from a later stage (exception/ertn); highest priority.
- valid1/valid2  input  1 each  slot carries a live instruction.
- pc1/pc2  input  PC_W each  instruction PCs.
- br_op1/br_op2  input  4 each  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 B, 8 BL, 9 JIRL; 10-15 treated as 0.
- rj1/rd1/rj2/rd2  input  PC_W each  source operands.
- offs1/offs2  input  PC_W each  sign-extended byte offset.
- in_pred_taken1/in_pred_taken2  input  1 each  front-end direction prediction.
- in_pred_addr1/in_pred_addr2  input  PC_W each  front-end predicted next PC.
- ex_valid1/ex_valid2, ex_is_bj_1/ex_is_bj_2, ex_pred_taken1/ex_pred_taken2, real_taken1/real_taken2  output  1 each  registered BPU update bus.
- ex_pc_1/ex_pc_2, real_addr1/real_addr2, pred_addr1/pred_addr2  output  PC_W each  registered BPU update bus.
- redirect_valid  output  1  IF must refetch from redirect_pc.
- redirect_ready  input  1  IF accepts the redirect.
- redirect_pc  output  PC_W  corrected fetch PC.
- br_cnt/mis_cnt  output  32 each  resolved-branch and mispredict counters.

Behaviour:
- Reset: every output 0 except redirect_pc=RESET_PC. in_ready reads 1 combinationally from the first cycle after reset. FSM in IDLE; counters 0.
- Accept: a packet is accepted when in_valid & in_ready & !flush_in.
- Latency: the update bus is registered. An acceptance in cycle N drives the bus in cycle N+1 for exactly one cycle; in all other cycles ex_valid1/ex_valid2 are 0.
- Direction: is_bj = op in 1..9.
  - real_taken: BEQ rj==rd; BNE rj!=rd; BLT/BGE signed compare; BLTU/BGEU unsigned compare; ops 7/8/9 always taken.
  - Non-branch slots: real_taken=0.
- Targets: taken target = pc+offs (ops 1-8) or rj+offs (op 9), truncated to PC_W. Not-taken or non-branch: real_addr=pc+4.
- Mispredict: slot k mispredicts if valid_k & (in_pred_addr_k != real_addr_k). A wrong direction with a correct address is not a mispredict.
- Slot ordering:
  - If slot 1 mispredicts, slot 2 is younger and squashed: ex_valid2=0, not counted. Redirect goes to real_addr1.
  - Otherwise, if slot 2 mispredicts, redirect goes to real_addr2.
- Pass-through: ex_pc_k, ex_pred_taken_k and pred_addr_k are the accepted inputs. ex_valid_k = valid_k after squash.
- FSM, IDLE:
  - in_ready=1, redirect_valid=0.
  - An accepted packet with a mispredict loads redirect_pc and moves to REDIR in cycle N+1.
- FSM, REDIR:
  - redirect_valid=1, in_ready=0, redirect_pc held stable.
  - When redirect_ready=1, go to IDLE next cycle; the handshake completes in that cycle.
  - redirect_ready may already be high in the first REDIR cycle, giving a 1-cycle redirect pulse.
- flush_in in any state:
  - Next cycle: FSM=IDLE, redirect_valid=0, update bus cleared.
  - No acceptance that cycle.
  - If flush_in arrives in cycle N+1 together with the registered bus from an acceptance in cycle N, that bus still reaches the BPU (it is already registered), but the pending redirect is dropped.
- Counters:
  - br_cnt += number of slots with ex_valid & ex_is_bj (0-2) per output cycle.
  - mis_cnt += 1 per redirect entered.
  - Both wrap modulo 2^32 and are updated from the registered bus.
- Reset mid-REDIR: returns to the reset state within one cycle; no redirect is issued.

Test Plan:
1. BEQ pc1=0x1c000100, rj=rd=5, offs=0x40, in_pred_addr1=0x1c000140 -> N+1: ex_valid1=1, real_taken1=1, real_addr1=0x1c000140; no redirect; br_cnt=1.
2. BNE pc1=0x1c000200, rj=rd=7, pred_taken1=1, in_pred_addr1=0x1c000280 -> real_taken1=0, real_addr1=0x1c000204; redirect_valid=1, redirect_pc=0x1c000204; in_ready=0 until redirect_ready; mis_cnt=1.
3. Slot 1 JIRL rj=0x1c001000, offs=8, mispredicted; slot 2 BLT valid -> ex_valid2=0, redirect_pc=0x1c001008, br_cnt+=1.
4. Slot 1 plain op, slot 2 BLTU rj=1, rd=0xFFFFFFFF, pred not-taken -> real_taken2=1, redirect to pc2+offs2; BGE with the same operands resolves taken (1 >= -1 signed).
5. Hold redirect_ready=0 for 5 cycles in REDIR -> redirect_valid and redirect_pc stable, in_valid ignored; assert flush_in in cycle 3 -> IDLE next cycle, redirect_valid=0, mis_cnt unchanged from entry.
6. Preload via 2^32-1 accepted branches (or force) then one branch -> br_cnt wraps to 0; cpu_rst asserted mid-REDIR -> all outputs reset next cycle, redirect_pc=RESET_PC.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage dual-slot branch resolver, BPU update bus and IF redirect handshake
module branch_resolve_unit #(
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h1c000000
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush_in,
  input  logic            valid1,
  input  logic            valid2,
  input  logic [PC_W-1:0] pc1,
  input  logic [PC_W-1:0] pc2,
  input  logic [3:0]      br_op1,
  input  logic [3:0]      br_op2,
  input  logic [PC_W-1:0] rj1,
  input  logic [PC_W-1:0] rd1,
  input  logic [PC_W-1:0] rj2,
  input  logic [PC_W-1:0] rd2,
  input  logic [PC_W-1:0] offs1,
  input  logic [PC_W-1:0] offs2,
  input  logic            in_pred_taken1,
  input  logic            in_pred_taken2,
  input  logic [PC_W-1:0] in_pred_addr1,
  input  logic [PC_W-1:0] in_pred_addr2,
  output logic            ex_valid1,
  output logic            ex_valid2,
  output logic            ex_is_bj_1,
  output logic            ex_is_bj_2,
  output logic            ex_pred_taken1,
  output logic            ex_pred_taken2,
  output logic            real_taken1,
  output logic            real_taken2,
  output logic [PC_W-1:0] ex_pc_1,
  output logic [PC_W-1:0] ex_pc_2,
  output logic [PC_W-1:0] real_addr1,
  output logic [PC_W-1:0] real_addr2,
  output logic [PC_W-1:0] pred_addr1,
  output logic [PC_W-1:0] pred_addr2,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mis_cnt
);
  typedef enum logic {IDLE, REDIR} state_t;
  state_t state, state_next;
  logic accept, is_bj1, is_bj2, tk1, tk2, mis1, mis2, ex_mis;
  logic [PC_W-1:0] addr1, addr2;
  function automatic logic bj_f(input logic [3:0] op);
    return op inside {[4'd1:4'd9]};
  endfunction
  function automatic logic taken_f(input logic [3:0] op, input logic [PC_W-1:0] a, input logic [PC_W-1:0] b);
    return op == 4'd1 ? a == b :
           op == 4'd2 ? a != b :
           op == 4'd3 ? $signed(a) < $signed(b) :
           op == 4'd4 ? $signed(a) >= $signed(b) :
           op == 4'd5 ? a < b :
           op == 4'd6 ? a >= b :
           op inside {[4'd7:4'd9]};
  endfunction
  function automatic logic [PC_W-1:0] addr_f(input logic tk, input logic [3:0] op, input logic [PC_W-1:0] pc,
                                             input logic [PC_W-1:0] rj, input logic [PC_W-1:0] offs);
    return tk ? (op == 4'd9 ? rj : pc) + offs : pc + PC_W'(4);
  endfunction
  // resolve both slots, then pick the oldest mispredict; slot 2 is squashed behind a slot-1 mispredict
  always_comb begin
    in_ready = state == IDLE;
    redirect_valid = state == REDIR;
    accept = in_valid & in_ready & ~flush_in;
    is_bj1 = bj_f(br_op1);
    is_bj2 = bj_f(br_op2);
    tk1 = taken_f(br_op1, rj1, rd1);
    tk2 = taken_f(br_op2, rj2, rd2);
    addr1 = addr_f(tk1, br_op1, pc1, rj1, offs1);
    addr2 = addr_f(tk2, br_op2, pc2, rj2, offs2);
    mis1 = valid1 & (in_pred_addr1 != addr1);
    mis2 = ~mis1 & valid2 & (in_pred_addr2 != addr2);
    state_next = flush_in ? IDLE :
                 state == IDLE ? (accept & (mis1 | mis2) ? REDIR : IDLE) :
                 (redirect_ready ? IDLE : REDIR);
  end
  // update bus is live for exactly one cycle after an acceptance; counters follow the registered bus
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state <= IDLE;
      redirect_pc <= RESET_PC;
      ex_valid1 <= 1'b0;
      ex_valid2 <= 1'b0;
      ex_is_bj_1 <= 1'b0;
      ex_is_bj_2 <= 1'b0;
      ex_pred_taken1 <= 1'b0;
      ex_pred_taken2 <= 1'b0;
      real_taken1 <= 1'b0;
      real_taken2 <= 1'b0;
      ex_pc_1 <= '0;
      ex_pc_2 <= '0;
      real_addr1 <= '0;
      real_addr2 <= '0;
      pred_addr1 <= '0;
      pred_addr2 <= '0;
      ex_mis <= 1'b0;
      br_cnt <= '0;
      mis_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept & (mis1 | mis2)) redirect_pc <= mis1 ? addr1 : addr2;
      ex_valid1 <= accept & valid1;
      ex_valid2 <= accept & valid2 & ~mis1;
      ex_is_bj_1 <= accept & is_bj1;
      ex_is_bj_2 <= accept & is_bj2;
      ex_pred_taken1 <= accept & in_pred_taken1;
      ex_pred_taken2 <= accept & in_pred_taken2;
      real_taken1 <= accept & tk1;
      real_taken2 <= accept & tk2;
      ex_pc_1 <= accept ? pc1 : '0;
      ex_pc_2 <= accept ? pc2 : '0;
      real_addr1 <= accept ? addr1 : '0;
      real_addr2 <= accept ? addr2 : '0;
      pred_addr1 <= accept ? in_pred_addr1 : '0;
      pred_addr2 <= accept ? in_pred_addr2 : '0;
      ex_mis <= accept & (mis1 | mis2);
      br_cnt <= br_cnt + {31'b0, ex_valid1 & ex_is_bj_1} + {31'b0, ex_valid2 & ex_is_bj_2};
      mis_cnt <= mis_cnt + {31'b0, ex_mis};
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
  logic cpu_clk, cpu_rst, in_valid, in_ready, flush_in, valid1, valid2;
  logic [31:0] pc1, pc2, rj1, rd1, rj2, rd2, offs1, offs2, in_pred_addr1, in_pred_addr2;
  logic [3:0] br_op1, br_op2;
  logic in_pred_taken1, in_pred_taken2;
  logic ex_valid1, ex_valid2, ex_is_bj_1, ex_is_bj_2, ex_pred_taken1, ex_pred_taken2, real_taken1, real_taken2;
  logic [31:0] ex_pc_1, ex_pc_2, real_addr1, real_addr2, pred_addr1, pred_addr2;
  logic redirect_valid, redirect_ready;
  logic [31:0] redirect_pc, br_cnt, mis_cnt;
  int errors = 0;
  int checks = 0;
  branch_resolve_unit dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .in_valid(in_valid), .in_ready(in_ready), .flush_in(flush_in),
    .valid1(valid1), .valid2(valid2), .pc1(pc1), .pc2(pc2), .br_op1(br_op1), .br_op2(br_op2),
    .rj1(rj1), .rd1(rd1), .rj2(rj2), .rd2(rd2), .offs1(offs1), .offs2(offs2),
    .in_pred_taken1(in_pred_taken1), .in_pred_taken2(in_pred_taken2),
    .in_pred_addr1(in_pred_addr1), .in_pred_addr2(in_pred_addr2),
    .ex_valid1(ex_valid1), .ex_valid2(ex_valid2), .ex_is_bj_1(ex_is_bj_1), .ex_is_bj_2(ex_is_bj_2),
    .ex_pred_taken1(ex_pred_taken1), .ex_pred_taken2(ex_pred_taken2),
    .real_taken1(real_taken1), .real_taken2(real_taken2), .ex_pc_1(ex_pc_1), .ex_pc_2(ex_pc_2),
    .real_addr1(real_addr1), .real_addr2(real_addr2), .pred_addr1(pred_addr1), .pred_addr2(pred_addr2),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;
  task automatic slot1(input logic v, input logic [3:0] op, input logic [31:0] pc, input logic [31:0] rj,
                       input logic [31:0] rd, input logic [31:0] offs, input logic pt, input logic [31:0] pa);
    valid1 = v; br_op1 = op; pc1 = pc; rj1 = rj; rd1 = rd; offs1 = offs; in_pred_taken1 = pt; in_pred_addr1 = pa;
  endtask
  task automatic slot2(input logic v, input logic [3:0] op, input logic [31:0] pc, input logic [31:0] rj,
                       input logic [31:0] rd, input logic [31:0] offs, input logic pt, input logic [31:0] pa);
    valid2 = v; br_op2 = op; pc2 = pc; rj2 = rj; rd2 = rd; offs2 = offs; in_pred_taken2 = pt; in_pred_addr2 = pa;
  endtask
  task automatic test_reset;
    cpu_rst = 1; in_valid = 0; flush_in = 0; redirect_ready = 0;
    slot1(0, 0, 0, 0, 0, 0, 0, 0); slot2(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge cpu_clk);
    checks++; if (ex_valid1 !== 1'b0) begin errors++; $display("FAIL rst_ex_valid1 got=%h exp=0", ex_valid1); end
    checks++; if (ex_valid2 !== 1'b0) begin errors++; $display("FAIL rst_ex_valid2 got=%h exp=0", ex_valid2); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_redirect_valid got=%h exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h1c000000) begin errors++; $display("FAIL rst_redirect_pc got=%h exp=1c000000", redirect_pc); end
    checks++; if (br_cnt !== 32'h0) begin errors++; $display("FAIL rst_br_cnt got=%h exp=0", br_cnt); end
    checks++; if (mis_cnt !== 32'h0) begin errors++; $display("FAIL rst_mis_cnt got=%h exp=0", mis_cnt); end
    checks++; if (real_addr1 !== 32'h0) begin errors++; $display("FAIL rst_real_addr1 got=%h exp=0", real_addr1); end
    cpu_rst = 0;
    @(negedge cpu_clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%h exp=1", in_ready); end
  endtask
  task automatic test_beq;
    slot1(1, 1, 32'h1c000100, 5, 5, 32'h40, 1, 32'h1c000140); slot2(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1;
    @(negedge cpu_clk); in_valid = 0;
    checks++; if (ex_valid1 !== 1'b1) begin errors++; $display("FAIL beq_ex_valid1 got=%h exp=1", ex_valid1); end
    checks++; if (real_taken1 !== 1'b1) begin errors++; $display("FAIL beq_real_taken1 got=%h exp=1", real_taken1); end
    checks++; if (real_addr1 !== 32'h1c000140) begin errors++; $display("FAIL beq_real_addr1 got=%h exp=1c000140", real_addr1); end
    checks++; if (ex_pc_1 !== 32'h1c000100) begin errors++; $display("FAIL beq_ex_pc_1 got=%h exp=1c000100", ex_pc_1); end
    checks++; if (ex_valid2 !== 1'b0) begin errors++; $display("FAIL beq_ex_valid2 got=%h exp=0", ex_valid2); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL beq_redirect got=%h exp=0", redirect_valid); end
    @(negedge cpu_clk);
    checks++; if (ex_valid1 !== 1'b0) begin errors++; $display("FAIL beq_one_cycle got=%h exp=0", ex_valid1); end
    checks++; if (br_cnt !== 32'd1) begin errors++; $display("FAIL beq_br_cnt got=%h exp=1", br_cnt); end
    checks++; if (mis_cnt !== 32'd0) begin errors++; $display("FAIL beq_mis_cnt got=%h exp=0", mis_cnt); end
  endtask
  task automatic test_mispredict;
    slot1(1, 2, 32'h1c000200, 7, 7, 32'h80, 1, 32'h1c000280);
    in_valid = 1;
    @(negedge cpu_clk); in_valid = 0;
    checks++; if (real_taken1 !== 1'b0) begin errors++; $display("FAIL bne_real_taken1 got=%h exp=0", real_taken1); end
    checks++; if (real_addr1 !== 32'h1c000204) begin errors++; $display("FAIL bne_real_addr1 got=%h exp=1c000204", real_addr1); end
    checks++; if (ex_pred_taken1 !== 1'b1) begin errors++; $display("FAIL bne_ex_pred_taken1 got=%h exp=1", ex_pred_taken1); end
    checks++; if (pred_addr1 !== 32'h1c000280) begin errors++; $display("FAIL bne_pred_addr1 got=%h exp=1c000280", pred_addr1); end
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL bne_redirect_valid got=%h exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h1c000204) begin errors++; $display("FAIL bne_redirect_pc got=%h exp=1c000204", redirect_pc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bne_in_ready got=%h exp=0", in_ready); end
    @(negedge cpu_clk);
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL bne_redirect_hold got=%h exp=1", redirect_valid); end
    checks++; if (mis_cnt !== 32'd1) begin errors++; $display("FAIL bne_mis_cnt got=%h exp=1", mis_cnt); end
    checks++; if (br_cnt !== 32'd2) begin errors++; $display("FAIL bne_br_cnt got=%h exp=2", br_cnt); end
    redirect_ready = 1;
    @(negedge cpu_clk); redirect_ready = 0;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL bne_redirect_done got=%h exp=0", redirect_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bne_in_ready_back got=%h exp=1", in_ready); end
  endtask
  task automatic test_squash;
    slot1(1, 9, 32'h1c000300, 32'h1c001000, 0, 32'h8, 0, 32'h1c000304);
    slot2(1, 3, 32'h1c000304, 1, 2, 32'h10, 0, 32'h1c000308);
    in_valid = 1;
    @(negedge cpu_clk); in_valid = 0;
    checks++; if (ex_valid1 !== 1'b1) begin errors++; $display("FAIL sq_ex_valid1 got=%h exp=1", ex_valid1); end
    checks++; if (ex_valid2 !== 1'b0) begin errors++; $display("FAIL sq_ex_valid2 got=%h exp=0", ex_valid2); end
    checks++; if (real_addr1 !== 32'h1c001008) begin errors++; $display("FAIL sq_real_addr1 got=%h exp=1c001008", real_addr1); end
    checks++; if (redirect_pc !== 32'h1c001008) begin errors++; $display("FAIL sq_redirect_pc got=%h exp=1c001008", redirect_pc); end
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL sq_redirect_valid got=%h exp=1", redirect_valid); end
    redirect_ready = 1;
    @(negedge cpu_clk); redirect_ready = 0;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL sq_pulse got=%h exp=0", redirect_valid); end
    checks++; if (br_cnt !== 32'd3) begin errors++; $display("FAIL sq_br_cnt got=%h exp=3", br_cnt); end
    checks++; if (mis_cnt !== 32'd2) begin errors++; $display("FAIL sq_mis_cnt got=%h exp=2", mis_cnt); end
  endtask
  task automatic test_compare;
    slot1(1, 0, 32'h1c000400, 0, 0, 0, 0, 32'h1c000404);
    slot2(1, 5, 32'h1c000404, 1, 32'hffffffff, 32'h20, 0, 32'h1c000408);
    in_valid = 1;
    @(negedge cpu_clk); in_valid = 0;
    checks++; if (ex_is_bj_1 !== 1'b0) begin errors++; $display("FAIL bltu_is_bj_1 got=%h exp=0", ex_is_bj_1); end
    checks++; if (real_addr1 !== 32'h1c000404) begin errors++; $display("FAIL bltu_real_addr1 got=%h exp=1c000404", real_addr1); end
    checks++; if (ex_valid2 !== 1'b1) begin errors++; $display("FAIL bltu_ex_valid2 got=%h exp=1", ex_valid2); end
    checks++; if (real_taken2 !== 1'b1) begin errors++; $display("FAIL bltu_real_taken2 got=%h exp=1", real_taken2); end
    checks++; if (real_addr2 !== 32'h1c000424) begin errors++; $display("FAIL bltu_real_addr2 got=%h exp=1c000424", real_addr2); end
    checks++; if (redirect_pc !== 32'h1c000424) begin errors++; $display("FAIL bltu_redirect_pc got=%h exp=1c000424", redirect_pc); end
    redirect_ready = 1;
    @(negedge cpu_clk); redirect_ready = 0;
    checks++; if (br_cnt !== 32'd4) begin errors++; $display("FAIL bltu_br_cnt got=%h exp=4", br_cnt); end
    checks++; if (mis_cnt !== 32'd3) begin errors++; $display("FAIL bltu_mis_cnt got=%h exp=3", mis_cnt); end
    slot1(1, 4, 32'h1c000500, 1, 32'hffffffff, 32'h30, 1, 32'h1c000530);
    slot2(1, 3, 32'h1c000504, 1, 32'hffffffff, 32'h10, 0, 32'h1c000508);
    in_valid = 1;
    @(negedge cpu_clk); in_valid = 0;
    checks++; if (real_taken1 !== 1'b1) begin errors++; $display("FAIL bge_real_taken1 got=%h exp=1", real_taken1); end
    checks++; if (real_addr1 !== 32'h1c000530) begin errors++; $display("FAIL bge_real_addr1 got=%h exp=1c000530", real_addr1); end
    checks++; if (real_taken2 !== 1'b0) begin errors++; $display("FAIL blt_real_taken2 got=%h exp=0", real_taken2); end
    checks++; if (real_addr2 !== 32'h1c000508) begin errors++; $display("FAIL blt_real_addr2 got=%h exp=1c000508", real_addr2); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL bge_redirect got=%h exp=0", redirect_valid); end
    @(negedge cpu_clk);
    checks++; if (br_cnt !== 32'd6) begin errors++; $display("FAIL bge_br_cnt got=%h exp=6", br_cnt); end
    slot1(1, 7, 32'h1c000600, 0, 0, 32'hfffffff0, 1, 32'h1c0005f0);
    slot2(1, 12, 32'h1c000604, 0, 0, 0, 0, 32'h1c000608);
    in_valid = 1;
    @(negedge cpu_clk); in_valid = 0;
    checks++; if (real_addr1 !== 32'h1c0005f0) begin errors++; $display("FAIL b_real_addr1 got=%h exp=1c0005f0", real_addr1); end
    checks++; if (ex_is_bj_2 !== 1'b0) begin errors++; $display("FAIL op12_is_bj_2 got=%h exp=0", ex_is_bj_2); end
    checks++; if (real_taken2 !== 1'b0) begin errors++; $display("FAIL op12_real_taken2 got=%h exp=0", real_taken2); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL b_redirect got=%h exp=0", redirect_valid); end
    @(negedge cpu_clk);
    checks++; if (br_cnt !== 32'd7) begin errors++; $display("FAIL b_br_cnt got=%h exp=7", br_cnt); end
  endtask
  task automatic test_redir_hold;
    slot1(1, 1, 32'h1c000700, 1, 2, 32'h100, 1, 32'h1c000800); slot2(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1;
    @(negedge cpu_clk);
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL hold_enter got=%h exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h1c000704) begin errors++; $display("FAIL hold_pc got=%h exp=1c000704", redirect_pc); end
    slot1(1, 2, 32'h1c000900, 1, 2, 32'h40, 0, 32'h1c000904);
    @(negedge cpu_clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready got=%h exp=0", in_ready); end
    checks++; if (ex_valid1 !== 1'b0) begin errors++; $display("FAIL hold_ignored got=%h exp=0", ex_valid1); end
    checks++; if (mis_cnt !== 32'd4) begin errors++; $display("FAIL hold_mis_cnt got=%h exp=4", mis_cnt); end
    @(negedge cpu_clk);
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL hold_valid3 got=%h exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h1c000704) begin errors++; $display("FAIL hold_pc3 got=%h exp=1c000704", redirect_pc); end
    flush_in = 1;
    @(negedge cpu_clk);
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL hold_flush got=%h exp=0", redirect_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_flush_ready got=%h exp=1", in_ready); end
    checks++; if (ex_valid1 !== 1'b0) begin errors++; $display("FAIL hold_flush_bus got=%h exp=0", ex_valid1); end
    flush_in = 0; in_valid = 0;
    @(negedge cpu_clk);
    checks++; if (mis_cnt !== 32'd4) begin errors++; $display("FAIL hold_mis_final got=%h exp=4", mis_cnt); end
    checks++; if (br_cnt !== 32'd8) begin errors++; $display("FAIL hold_br_cnt got=%h exp=8", br_cnt); end
  endtask
  task automatic test_flush;
    slot1(1, 2, 32'h1c000a00, 3, 3, 32'h40, 1, 32'h1c000a40);
    in_valid = 1;
    @(negedge cpu_clk); in_valid = 0; flush_in = 1;
    checks++; if (ex_valid1 !== 1'b1) begin errors++; $display("FAIL fl_bus_kept got=%h exp=1", ex_valid1); end
    @(negedge cpu_clk); flush_in = 0;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL fl_redirect_dropped got=%h exp=0", redirect_valid); end
    checks++; if (ex_valid1 !== 1'b0) begin errors++; $display("FAIL fl_bus_cleared got=%h exp=0", ex_valid1); end
    checks++; if (br_cnt !== 32'd9) begin errors++; $display("FAIL fl_br_cnt got=%h exp=9", br_cnt); end
    slot1(1, 1, 32'h1c000b00, 0, 0, 32'h4, 0, 32'h1c000b04);
    in_valid = 1; flush_in = 1;
    @(negedge cpu_clk); in_valid = 0; flush_in = 0;
    checks++; if (ex_valid1 !== 1'b0) begin errors++; $display("FAIL fl_no_accept got=%h exp=0", ex_valid1); end
  endtask
  task automatic test_wrap_and_reset;
    force dut.br_cnt = 32'hffffffff;
    slot1(1, 1, 32'h1c000c00, 4, 4, 32'h8, 1, 32'h1c000c08);
    in_valid = 1;
    @(negedge cpu_clk); in_valid = 0;
    release dut.br_cnt;
    @(negedge cpu_clk);
    checks++; if (br_cnt !== 32'h0) begin errors++; $display("FAIL wrap_br_cnt got=%h exp=0", br_cnt); end
    slot1(1, 1, 32'h1c000d00, 1, 2, 32'h20, 1, 32'h1c000d20);
    in_valid = 1;
    @(negedge cpu_clk); in_valid = 0;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL rr_enter got=%h exp=1", redirect_valid); end
    cpu_rst = 1;
    @(negedge cpu_clk); cpu_rst = 0;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rr_redirect got=%h exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h1c000000) begin errors++; $display("FAIL rr_redirect_pc got=%h exp=1c000000", redirect_pc); end
    checks++; if (mis_cnt !== 32'h0) begin errors++; $display("FAIL rr_mis_cnt got=%h exp=0", mis_cnt); end
    checks++; if (ex_valid1 !== 1'b0) begin errors++; $display("FAIL rr_ex_valid1 got=%h exp=0", ex_valid1); end
    @(negedge cpu_clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_in_ready got=%h exp=1", in_ready); end
    checks++; if (br_cnt !== 32'h0) begin errors++; $display("FAIL rr_br_cnt got=%h exp=0", br_cnt); end
  endtask
  initial begin
    test_reset;
    test_beq;
    test_mispredict;
    test_squash;
    test_compare;
    test_redir_hold;
    test_flush;
    test_wrap_and_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
